// File: rtl/shm_display_sequencer.sv
// Drives the IS31FL3731 I2C write controller: fixed init script, then 144-byte PWM frames on refresh.
// Optional SHM_BRIGHTNESS_EN scales each PWM byte by `brightness`. Without it the byte is written unchanged.
module shm_display_sequencer #(
    parameter int         REPEAT_SZ = 6,
    parameter int         MAX_RETRY = 3,
    parameter int         NUM_PWM   = 144,
    parameter logic [7:0] PWM_BASE  = 8'h24
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 refresh,
    input  logic                 restart,
    input  logic [7:0]           brightness,
    output logic [7:0]           pix_addr,
    input  logic [7:0]           pix_data,
    output logic                 activate,
    output logic [7:0]           location,
    output logic [7:0]           data,
    output logic [REPEAT_SZ-1:0] data_repeat,
    input  logic                 busy,
    input  logic                 success,
    input  logic                 abort,
    output logic                 init_done,
    output logic                 frame_done,
    output logic                 error
);

    localparam int RW       = $clog2(MAX_RETRY + 1);
    localparam int INIT_LEN = 8;

    typedef enum logic [2:0] {
        INIT_ISSUE,
        INIT_WAIT,
        IDLE,
        FETCH,
        PIX_ISSUE,
        PIX_WAIT,
        ERROR
    } state_t;

    typedef struct packed {
        logic [7:0]           loc;
        logic [7:0]           dat;
        logic [REPEAT_SZ-1:0] rep;
    } cmd_t;

    // Function page, shutdown, picture mode, wake, frame 0, then LED enables and blink off.
    function automatic cmd_t init_cmd(input logic [2:0] i);
        case (i)
            3'd0:    init_cmd = '{8'hFD, 8'h0B, REPEAT_SZ'(0)};
            3'd1:    init_cmd = '{8'h0A, 8'h00, REPEAT_SZ'(0)};
            3'd2:    init_cmd = '{8'h00, 8'h00, REPEAT_SZ'(0)};
            3'd3:    init_cmd = '{8'h01, 8'h00, REPEAT_SZ'(0)};
            3'd4:    init_cmd = '{8'h0A, 8'h01, REPEAT_SZ'(0)};
            3'd5:    init_cmd = '{8'hFD, 8'h00, REPEAT_SZ'(0)};
            3'd6:    init_cmd = '{8'h00, 8'hFF, REPEAT_SZ'(17)};
            default: init_cmd = '{8'h12, 8'h00, REPEAT_SZ'(17)};
        endcase
    endfunction

    state_t        state;
    logic [2:0]    idx;
    logic [RW-1:0] retry;
    logic [RW-1:0] retry_nxt;
    logic [7:0]    pix;
    logic [7:0]    pwm_byte;
    logic [7:0]    pwm_next;
    logic          pending;
    logic          seen_busy;
    logic          fetch_ph;
    logic          txn_end;
    logic          txn_fail;

`ifdef SHM_BRIGHTNESS_EN
    logic [15:0] scaled;
    assign scaled   = 16'(pix_data) * 16'(brightness);
    assign pwm_next = scaled[15:8];
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign pwm_next          = pix_data;
`endif

    assign retry_nxt = retry + 1'b1;
    assign txn_end   = seen_busy && !busy;
    // A busy drop carrying neither status is retried like an abort.
    assign txn_fail  = abort || !success;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= INIT_ISSUE;
            idx         <= '0;
            retry       <= '0;
            pix         <= '0;
            pwm_byte    <= '0;
            pending     <= 1'b0;
            seen_busy   <= 1'b0;
            fetch_ph    <= 1'b0;
            activate    <= 1'b0;
            location    <= '0;
            data        <= '0;
            data_repeat <= '0;
            pix_addr    <= '0;
            init_done   <= 1'b0;
            frame_done  <= 1'b0;
            error       <= 1'b0;
        end else begin
            activate   <= 1'b0;
            frame_done <= 1'b0;
            if (refresh && state != ERROR)
                pending <= 1'b1;

            case (state)
                INIT_ISSUE: begin
                    if (!busy) begin
                        activate                        <= 1'b1;
                        {location, data, data_repeat}   <= init_cmd(idx);
                        seen_busy                       <= 1'b0;
                        state                           <= INIT_WAIT;
                    end
                end

                INIT_WAIT: begin
                    if (!seen_busy) begin
                        if (busy)
                            seen_busy <= 1'b1;
                    end else if (txn_end) begin
                        if (!txn_fail) begin
                            retry <= '0;
                            if (idx == 3'(INIT_LEN - 1)) begin
                                init_done <= 1'b1;
                                state     <= IDLE;
                            end else begin
                                idx   <= idx + 3'd1;
                                state <= INIT_ISSUE;
                            end
                        end else begin
                            retry <= retry_nxt;
                            if (retry_nxt == RW'(MAX_RETRY)) begin
                                error <= 1'b1;
                                state <= ERROR;
                            end else begin
                                state <= INIT_ISSUE;
                            end
                        end
                    end
                end

                IDLE: begin
                    if (restart) begin
                        error     <= 1'b0;
                        init_done <= 1'b0;
                        idx       <= '0;
                        retry     <= '0;
                        state     <= INIT_ISSUE;
                    end else if (pending) begin
                        // The frame consumes the request now; anything arriving later queues one more frame.
                        pending  <= refresh;
                        pix      <= '0;
                        pix_addr <= '0;
                        fetch_ph <= 1'b0;
                        state    <= FETCH;
                    end
                end

                FETCH: begin
                    // Phase 0 presents the address, phase 1 sees the frame-buffer data.
                    fetch_ph <= 1'b1;
                    if (fetch_ph) begin
                        pwm_byte <= pwm_next;
                        state    <= PIX_ISSUE;
                    end
                end

                PIX_ISSUE: begin
                    if (!busy) begin
                        activate    <= 1'b1;
                        location    <= PWM_BASE + pix;
                        data        <= pwm_byte;
                        data_repeat <= '0;
                        seen_busy   <= 1'b0;
                        state       <= PIX_WAIT;
                    end
                end

                PIX_WAIT: begin
                    if (!seen_busy) begin
                        if (busy)
                            seen_busy <= 1'b1;
                    end else if (txn_end) begin
                        if (!txn_fail) begin
                            retry <= '0;
                            if (pix == 8'(NUM_PWM - 1)) begin
                                frame_done <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                pix      <= pix + 8'd1;
                                pix_addr <= pix + 8'd1;
                                fetch_ph <= 1'b0;
                                state    <= FETCH;
                            end
                        end else begin
                            retry <= retry_nxt;
                            if (retry_nxt == RW'(MAX_RETRY)) begin
                                error <= 1'b1;
                                state <= ERROR;
                            end else begin
                                state <= PIX_ISSUE;
                            end
                        end
                    end
                end

                ERROR: begin
                    location    <= '0;
                    data        <= '0;
                    data_repeat <= '0;
                    pix_addr    <= '0;
                    pending     <= 1'b0;
                    if (restart) begin
                        error     <= 1'b0;
                        init_done <= 1'b0;
                        idx       <= '0;
                        retry     <= '0;
                        state     <= INIT_ISSUE;
                    end
                end

                default: state <= INIT_ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_shm_display_sequencer.sv
// Randomized bench: I2C controller and frame-buffer models with a transaction-level reference of the expected writes.
module tb_shm_display_sequencer;

    localparam int NUM_PWM = 144;

    logic       clk = 1'b0;
    logic       reset_n, refresh, restart, busy, success, abort;
    logic [7:0] brightness, pix_data, pix_addr, location, data;
    logic [5:0] data_repeat;
    logic       activate, init_done, frame_done, error;

    always #5 clk = ~clk;

    shm_display_sequencer dut (
        .clk(clk), .reset_n(reset_n), .refresh(refresh), .restart(restart),
        .brightness(brightness), .pix_addr(pix_addr), .pix_data(pix_data),
        .activate(activate), .location(location), .data(data),
        .data_repeat(data_repeat), .busy(busy), .success(success), .abort(abort),
        .init_done(init_done), .frame_done(frame_done), .error(error)
    );

    typedef struct packed {
        logic [7:0] loc;
        logic [7:0] dat;
        logic [5:0] rep;
    } txn_t;

    txn_t       act_q[$];
    txn_t       exp_q[$];
    bit         resp_q[$];
    bit         abort_all;
    int         coincide_at;
    int         ref_asked, ref_done;
    int         ntxn;
    int         fd_cnt;
    logic [7:0] fb_mem [256];
    logic [7:0] fb_a;
    int         n_vec, n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic txn_t init_cmd(input int i);
        case (i)
            0: return '{8'hFD, 8'h0B, 6'd0};
            1: return '{8'h0A, 8'h00, 6'd0};
            2: return '{8'h00, 8'h00, 6'd0};
            3: return '{8'h01, 8'h00, 6'd0};
            4: return '{8'h0A, 8'h01, 6'd0};
            5: return '{8'hFD, 8'h00, 6'd0};
            6: return '{8'h00, 8'hFF, 6'd17};
            default: return '{8'h12, 8'h00, 6'd17};
        endcase
    endfunction

    function automatic logic [7:0] pwm_of(input logic [7:0] v, input logic [7:0] b);
`ifdef SHM_BRIGHTNESS_EN
        return 8'((int'(v) * int'(b)) / 256);
`else
        return v;
`endif
    endfunction

    task automatic exp_init();
        for (int i = 0; i < 8; i++) exp_q.push_back(init_cmd(i));
    endtask

    task automatic exp_frame();
        for (int p = 0; p < NUM_PWM; p++)
            exp_q.push_back('{8'(8'h24 + p), pwm_of(fb_mem[p], brightness), 6'd0});
    endtask

    task automatic wait_txn(input int n, input int budget);
        int t = 0;
        while (ntxn < n && t < budget) begin
            @(negedge clk);
            t++;
        end
    endtask

    // Wait for the expected number of writes, let the bus settle, then compare in order.
    task automatic drain(input string tag, input int budget);
        int t = 0;
        int n;
        while (act_q.size() < exp_q.size() && t < budget) begin
            @(negedge clk);
            t++;
        end
        repeat (40) @(negedge clk);
        check({tag, "_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_loc%0d", tag, i), act_q[i].loc, exp_q[i].loc);
            check($sformatf("%s_dat%0d", tag, i), act_q[i].dat, exp_q[i].dat);
            check($sformatf("%s_rep%0d", tag, i), act_q[i].rep, exp_q[i].rep);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic pulse_restart();
        @(negedge clk) restart = 1'b1;
        @(negedge clk) restart = 1'b0;
        check("restart_init_clr", init_done, 0);
        check("restart_err_clr", error, 0);
    endtask

    // Synchronous-read frame buffer: address seen in one cycle, data presented the next.
    initial begin
        pix_data = 8'h00;
        forever begin
            @(negedge clk);
            fb_a = pix_addr;
            @(posedge clk);
            #1 pix_data = fb_mem[fb_a];
        end
    end

    initial begin
        fd_cnt = 0;
        forever begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
        end
    end

    // I2C controller model, stepped once per falling edge.
    initial begin
        int   mstate, dly, cnt;
        bit   bad;
        txn_t cur;
        mstate = 0; dly = 0; cnt = 0; cur = '0;
        busy = 1'b0; success = 1'b0; abort = 1'b0; refresh = 1'b0;
        forever begin
            @(negedge clk);
            success = 1'b0;
            abort   = 1'b0;
            refresh = 1'b0;
            if (ref_asked > ref_done) begin
                refresh = 1'b1;
                ref_done++;
            end
            if (!reset_n) begin
                mstate = 0;
                busy   = 1'b0;
            end else begin
                if (mstate != 0) check("act_in_txn", activate, 0);
                case (mstate)
                    0: if (activate) begin
                        cur.loc = location;
                        cur.dat = data;
                        cur.rep = data_repeat;
                        act_q.push_back(cur);
                        ntxn++;
                        dly = $urandom_range(0, 2);
                        cnt = $urandom_range(1, 4);
                        if (dly == 0) begin
                            busy   = 1'b1;
                            mstate = 2;
                        end else begin
                            mstate = 1;
                        end
                    end
                    1: begin
                        dly--;
                        if (dly == 0) begin
                            busy   = 1'b1;
                            mstate = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            check("hold_loc", location, cur.loc);
                            check("hold_dat", data, cur.dat);
                            check("hold_rep", data_repeat, cur.rep);
                            busy = 1'b0;
                            bad  = (resp_q.size() > 0) ? resp_q.pop_front() : abort_all;
                            if (bad) abort = 1'b1;
                            else     success = 1'b1;
                            if (!bad && ntxn == coincide_at) refresh = 1'b1;
                            mstate = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin
        int base;
        n_vec = 0; n_err = 0; ntxn = 0;
        ref_asked = 0; ref_done = 0;
        abort_all = 1'b0; coincide_at = -1;
        reset_n = 1'b0; restart = 1'b0;
        brightness = 8'($urandom);
        for (int i = 0; i < 256; i++) fb_mem[i] = 8'(i) ^ 8'h5A;

        repeat (4) @(negedge clk);
        check("rst_activate", activate, 0);
        check("rst_location", location, 0);
        check("rst_data", data, 0);
        check("rst_repeat", data_repeat, 0);
        check("rst_pix_addr", pix_addr, 0);
        check("rst_init_done", init_done, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_error", error, 0);

        reset_n = 1'b1;
        @(negedge clk);
        check("first_activate", activate, 1);
        exp_init();
        drain("init", 2000);
        check("init_done", init_done, 1);
        check("init_error", error, 0);

        // Frame buffer returns addr^0x5A.
        ref_asked++;
        exp_frame();
        drain("frame_xor", 5000);
        check("frame_done_1", fd_cnt, 1);

        // Two mid-frame requests plus one coincident with the last ack: exactly one extra frame.
        for (int i = 0; i < 256; i++) fb_mem[i] = 8'($urandom);
        base = ntxn;
        coincide_at = base + NUM_PWM;
        ref_asked++;
        exp_frame();
        exp_frame();
        wait_txn(base + $urandom_range(5, 60), 3000);
        ref_asked++;
        wait_txn(base + $urandom_range(70, 130), 3000);
        ref_asked++;
        drain("frame_multi", 9000);
        check("frame_done_3", fd_cnt, 3);

        // Only the coincident request: it must survive the end of the frame.
        brightness = 8'($urandom);
        base = ntxn;
        coincide_at = base + NUM_PWM;
        ref_asked++;
        exp_frame();
        exp_frame();
        drain("frame_coinc", 9000);
        check("frame_done_5", fd_cnt, 5);
        coincide_at = -1;

        // Entry 2 aborts twice then succeeds.
        resp_q = '{1'b0, 1'b0, 1'b1, 1'b1};
        pulse_restart();
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(init_cmd(i));
            if (i == 2) begin
                exp_q.push_back(init_cmd(2));
                exp_q.push_back(init_cmd(2));
            end
        end
        drain("retry", 3000);
        check("retry_init_done", init_done, 1);
        check("retry_error", error, 0);

        // Every transaction aborts: error after the third attempt, refresh ignored.
        abort_all = 1'b1;
        pulse_restart();
        for (int i = 0; i < 3; i++) exp_q.push_back(init_cmd(0));
        drain("abort_all", 2000);
        check("err_set", error, 1);
        check("err_init_done", init_done, 0);
        check("err_location", location, 0);
        ref_asked++;
        repeat (30) @(negedge clk);
        check("err_quiet", act_q.size(), 0);
        check("err_still", error, 1);
        abort_all = 1'b0;
        pulse_restart();
        exp_init();
        drain("reinit", 2000);
        check("reinit_done", init_done, 1);
        check("reinit_no_frame", fd_cnt, 5);

        // Brightness scaling spot check with constant expectations.
        for (int i = 0; i < 256; i++) fb_mem[i] = 8'hFF;
        brightness = 8'h80;
        ref_asked++;
        for (int p = 0; p < NUM_PWM; p++) begin
`ifdef SHM_BRIGHTNESS_EN
            exp_q.push_back('{8'(8'h24 + p), 8'h7F, 6'd0});
`else
            exp_q.push_back('{8'(8'h24 + p), 8'hFF, 6'd0});
`endif
        end
        drain("bright", 5000);
        check("frame_done_6", fd_cnt, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
